mcp3008_reader: RTL and testbench

SPI master for the MCP3008 10-bit ADC on the breadboard controller. On a one-cycle `start` request from the command decoder (e.g. after `cmd_get_mcp`), it runs one complete conversion frame on the `mcp_*` pins and presents the 10-bit result on a valid/ready output. The FT245 transmit path consumes that output. The block sits between the command decoder and the FT245 TX packer, in the `clk_in` domain.

---
 rtl/mcp3008_reader_if.sv | 21 ++
 rtl/mcp3008_reader.sv | 189 ++++++++++++++++++
 tb/tb_mcp3008_reader.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcp3008_reader_if.sv
// Command/result bundle between the command decoder, the MCP3008 reader and the FT245 TX packer.
// master = decoder/consumer side, slave = the reader.
interface mcp3008_reader_if;
  logic       start;
  logic [2:0] channel;
  logic       single_ended;
  logic       busy;
  logic [9:0] data;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output start, channel, single_ended, data_ready,
    input  busy, data, data_valid
  );

  modport slave (
    input  start, channel, single_ended, data_ready,
    output busy, data, data_valid
  );
endinterface

// File: rtl/mcp3008_reader.sv
// SPI master running one 17-clock MCP3008 conversion frame per start; result on valid/ready.
// Optional MCP3008_AVG_EN: four frames per start, data = truncated mean of the four results.
module mcp3008_reader #(
  parameter int CLK_DIV = 8,
  parameter int CS_IDLE = 8
) (
  input  logic               clk_in,
  input  logic               rst_n,
  mcp3008_reader_if.slave    cmd,
  output logic               mcp_dclk,
  output logic               mcp_din,
  input  logic               mcp_dout,
  output logic               mcp_cs_n
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [7:0] IDLE_LAST = 8'(CS_IDLE - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] edge_q, edge_d;
  logic [4:0] cmd_q, cmd_d;
  logic [9:0] sh_q, sh_d;
  logic [9:0] data_q, data_d;
  logic       dv_q, dv_d;
  logic       dclk_q, dclk_d;
  logic       din_q, din_d;
  logic       cs_n_q, cs_n_d;
  logic       accept;

`ifdef MCP3008_AVG_EN
  logic [3:0]  cfg_q, cfg_d;
  logic [1:0]  frame_q, frame_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] acc_sum;
  assign acc_sum = acc_q + {2'b00, sh_q};
`endif

  assign accept = cmd.start && !dv_q && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    edge_d  = edge_q;
    cmd_d   = cmd_q;
    sh_d    = sh_q;
    data_d  = data_q;
    dv_d    = dv_q;
    dclk_d  = dclk_q;
    din_d   = din_q;
    cs_n_d  = cs_n_q;
`ifdef MCP3008_AVG_EN
    cfg_d   = cfg_q;
    frame_d = frame_q;
    acc_d   = acc_q;
`endif
    if (dv_q && cmd.data_ready) dv_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SETUP;
          cnt_d   = 8'd0;
          cs_n_d  = 1'b0;
          din_d   = 1'b1;
          // Remaining command bits after the start bit, shifted out on falling edges.
          cmd_d   = {cmd.single_ended, cmd.channel, 1'b0};
`ifdef MCP3008_AVG_EN
          cfg_d   = {cmd.single_ended, cmd.channel};
          frame_d = 2'd0;
          acc_d   = 12'd0;
`endif
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = 8'd0;
          dclk_d  = 1'b1;
          edge_d  = 5'd1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd0;
          if (!dclk_q) begin
            dclk_d = 1'b1;
            edge_d = edge_q + 5'd1;
            // Rising edges 8..17 carry B9..B0.
            if (edge_q >= 5'd7) sh_d = {sh_q[8:0], mcp_dout};
          end else begin
            dclk_d = 1'b0;
            if (edge_q == 5'd17) begin
              state_d = S_HOLD;
              cs_n_d  = 1'b1;
              din_d   = 1'b0;
`ifdef MCP3008_AVG_EN
              if (frame_q == 2'd3) begin
                data_d  = acc_sum[11:2];
                dv_d    = 1'b1;
                frame_d = 2'd0;
              end else begin
                acc_d   = acc_sum;
                frame_d = frame_q + 2'd1;
              end
`else
              data_d = sh_q;
              dv_d   = 1'b1;
`endif
            end else begin
              din_d = cmd_q[4];
              cmd_d = {cmd_q[3:0], 1'b0};
            end
          end
        end
      end
      default: begin
        if (cnt_q != IDLE_LAST) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d   = 8'd0;
          state_d = S_IDLE;
`ifdef MCP3008_AVG_EN
          // frame_q is nonzero only while frames of the current average remain.
          if (frame_q != 2'd0) begin
            state_d = S_SETUP;
            cs_n_d  = 1'b0;
            din_d   = 1'b1;
            cmd_d   = {cfg_q, 1'b0};
          end
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      edge_q  <= 5'd0;
      cmd_q   <= 5'd0;
      sh_q    <= 10'd0;
      data_q  <= 10'd0;
      dv_q    <= 1'b0;
      dclk_q  <= 1'b0;
      din_q   <= 1'b0;
      cs_n_q  <= 1'b1;
`ifdef MCP3008_AVG_EN
      cfg_q   <= 4'd0;
      frame_q <= 2'd0;
      acc_q   <= 12'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      cmd_q   <= cmd_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      dclk_q  <= dclk_d;
      din_q   <= din_d;
      cs_n_q  <= cs_n_d;
`ifdef MCP3008_AVG_EN
      cfg_q   <= cfg_d;
      frame_q <= frame_d;
      acc_q   <= acc_d;
`endif
    end
  end

  assign cmd.busy       = (state_q != S_IDLE);
  assign cmd.data       = data_q;
  assign cmd.data_valid = dv_q;
  assign mcp_dclk       = dclk_q;
  assign mcp_din        = din_q;
  assign mcp_cs_n       = cs_n_q;

endmodule

// File: tb/tb_mcp3008_reader.sv
// Directed bench for mcp3008_reader: ADC model on the SPI pins, table of conversions,
// plus hand-written backpressure, ignored-start, mid-frame reset and averaging sequences.
module tb_mcp3008_reader;
  localparam int DIV  = 8;
  localparam int IDLE = 8;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b0;
  logic mcp_dclk, mcp_din, mcp_cs_n;
  logic mcp_dout = 1'b0;
  int   cyc = 0;

  mcp3008_reader_if bif ();

  mcp3008_reader #(.CLK_DIV(DIV), .CS_IDLE(IDLE)) dut (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .cmd      (bif),
    .mcp_dclk (mcp_dclk),
    .mcp_din  (mcp_din),
    .mcp_dout (mcp_dout),
    .mcp_cs_n (mcp_cs_n)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // Stimulus-side ADC settings
  logic [9:0] adc_val = 10'h000;
  logic       force1  = 1'b0;
  logic       avg_mode = 1'b0;

  // Monitor state
  int cs_fall_cnt = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, rise1_cyc = 0;
  int rise_cnt = 0, fall_cnt = 0, dclk_bad = 0, dv_rise_cyc = 0, dv_cycles = 0;
  int busy_fall_cyc = 0, avg_idx = 0, min_gap = 99999;
  bit cs_rise_seen = 0;
  logic [4:0] din_bits = 5'd0;
  logic prev_cs = 1'b1, prev_dclk = 1'b0, prev_dv = 1'b0, prev_busy = 1'b0;
  logic [9:0] cur;

  always @(negedge clk_in) begin
    if (prev_cs && !mcp_cs_n) begin
      cs_fall_cnt++;
      cs_fall_cyc = cyc;
      rise_cnt = 0;
      fall_cnt = 0;
      if (avg_mode) begin
        if (cs_rise_seen && avg_idx > 0 && (cyc - cs_rise_cyc) < min_gap) min_gap = cyc - cs_rise_cyc;
        avg_idx++;
      end
    end
    if (!prev_cs && mcp_cs_n) begin
      cs_rise_cyc = cyc;
      cs_rise_seen = 1;
    end
    if (!prev_dclk && mcp_dclk && !mcp_cs_n) begin
      rise_cnt++;
      if (rise_cnt == 1) rise1_cyc = cyc;
      if (rise_cnt <= 5) din_bits = {din_bits[3:0], mcp_din};
    end
    // ADC shifts B9..B0 out after falling edges 7..16
    if (prev_dclk && !mcp_dclk && !mcp_cs_n) begin
      fall_cnt++;
      if (fall_cnt >= 7 && fall_cnt <= 16) begin
        cur = avg_mode ? 10'(10'h100 + avg_idx - 1) : adc_val;
        mcp_dout = cur[16 - fall_cnt];
      end
    end
    if (force1) mcp_dout = 1'b1;
    if (mcp_cs_n && mcp_dclk) dclk_bad++;
    if (!prev_dv && bif.data_valid) dv_rise_cyc = cyc;
    if (bif.data_valid) dv_cycles++;
    if (prev_busy && !bif.busy) busy_fall_cyc = cyc;
    prev_cs   = mcp_cs_n;
    prev_dclk = mcp_dclk;
    prev_dv   = bif.data_valid;
    prev_busy = bif.busy;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  int t_start;

  task automatic do_start();
    @(posedge clk_in); #1;
    bif.start = 1'b1;
    t_start = cyc;
    @(posedge clk_in); #1;
    bif.start = 1'b0;
  endtask

  task automatic wait_dv(input int max_cyc);
    bit got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in); #1;
      if (bif.data_valid) begin
        got = 1;
        break;
      end
    end
    chk("dv_arrives", int'(got), 1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit got = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk_in); #1;
      if (!bif.busy) begin
        got = 1;
        break;
      end
    end
    chk("busy_clears", int'(got), 1);
  endtask

  typedef struct {
    logic [2:0] ch;
    logic       se;
    logic [9:0] adc;
    logic       f1;
    logic [9:0] exp_data;
    logic [4:0] exp_din;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int frames0, dvc0, bp_bad, bp_cs_bad;
    bit dv_seen;
    logic [9:0] saved;
    bit hit;

    vecs[0] = '{ch: 3'd3, se: 1'b1, adc: 10'h2A5, f1: 1'b0, exp_data: 10'h2A5, exp_din: 5'b11011};
    vecs[1] = '{ch: 3'd0, se: 1'b0, adc: 10'h000, f1: 1'b1, exp_data: 10'h3FF, exp_din: 5'b10000};
    vecs[2] = '{ch: 3'd5, se: 1'b1, adc: 10'h001, f1: 1'b0, exp_data: 10'h001, exp_din: 5'b11101};
    vecs[3] = '{ch: 3'd6, se: 1'b0, adc: 10'h200, f1: 1'b0, exp_data: 10'h200, exp_din: 5'b10110};

    bif.start = 1'b0;
    bif.channel = 3'd0;
    bif.single_ended = 1'b0;
    bif.data_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    @(negedge clk_in); #1;
    chk("rst_cs_n", int'(mcp_cs_n), 1);
    chk("rst_dclk", int'(mcp_dclk), 0);
    chk("rst_din", int'(mcp_din), 0);
    chk("rst_busy", int'(bif.busy), 0);
    chk("rst_dv", int'(bif.data_valid), 0);
    chk("rst_data", int'(bif.data), 0);

    for (int i = 0; i < 4; i++) begin
      bif.channel = vecs[i].ch;
      bif.single_ended = vecs[i].se;
      adc_val = vecs[i].adc;
      force1 = vecs[i].f1;
      dvc0 = dv_cycles;
      do_start();
      wait_dv(8000);
      chk($sformatf("v%0d_data", i), int'(bif.data), int'(vecs[i].exp_data));
      chk($sformatf("v%0d_din", i), int'(din_bits), int'(vecs[i].exp_din));
      chk($sformatf("v%0d_edges", i), rise_cnt, 17);
`ifndef MCP3008_AVG_EN
      chk($sformatf("v%0d_cs_fall", i), cs_fall_cyc - t_start, 1);
      chk($sformatf("v%0d_rise1", i), rise1_cyc - t_start, 1 + DIV);
      chk($sformatf("v%0d_cs_rise", i), cs_rise_cyc - t_start, 273);
      chk($sformatf("v%0d_dv_rise", i), dv_rise_cyc - t_start, 273);
`endif
      wait_idle(100);
      chk($sformatf("v%0d_busy_fall", i), busy_fall_cyc - cs_rise_cyc, IDLE);
      chk($sformatf("v%0d_dv_once", i), dv_cycles - dvc0, 1);
    end
    force1 = 1'b0;

    // Backpressure with an ignored second start at T+300
    bif.channel = 3'd3;
    bif.single_ended = 1'b1;
    adc_val = 10'h2A5;
    bif.data_ready = 1'b0;
    frames0 = cs_fall_cnt;
    bp_bad = 0;
    bp_cs_bad = 0;
    dv_seen = 0;
    saved = 10'd0;
    do_start();
    for (int i = 0; i < 500; i++) begin
      @(posedge clk_in); #1;
      bif.start = (cyc == t_start + 300);
      @(negedge clk_in); #1;
      if (dv_seen) begin
        if (!bif.data_valid || bif.data !== saved) bp_bad++;
        if (!mcp_cs_n) bp_cs_bad++;
      end else if (bif.data_valid) begin
        dv_seen = 1;
        saved = bif.data;
      end
    end
    bif.start = 1'b0;
    if (!dv_seen) begin
      wait_dv(8000);
      saved = bif.data;
    end
    repeat (20) begin
      @(negedge clk_in); #1;
      if (!bif.data_valid || bif.data !== saved) bp_bad++;
      if (!mcp_cs_n) bp_cs_bad++;
    end
    chk("bp_data", int'(saved), 10'h2A5);
    chk("bp_stable", bp_bad, 0);
    chk("bp_cs_high", bp_cs_bad, 0);
    // Handshake and a new start in the same cycle: start must be dropped
    @(posedge clk_in); #1;
    bif.data_ready = 1'b1;
    bif.start = 1'b1;
    @(negedge clk_in); #1;
    chk("hs_dv_before", int'(bif.data_valid), 1);
    @(posedge clk_in); #1;
    bif.start = 1'b0;
    @(negedge clk_in); #1;
    chk("hs_dv_after", int'(bif.data_valid), 0);
    repeat (30) @(negedge clk_in);
    #1;
    chk("bp_frames", cs_fall_cnt - frames0, 1);
    chk("hs_idle", int'(bif.busy), 0);

    // Start while busy is ignored
    frames0 = cs_fall_cnt;
    dvc0 = dv_cycles;
    do_start();
    repeat (50) @(posedge clk_in);
    #1 bif.start = 1'b1;
    @(posedge clk_in); #1;
    bif.start = 1'b0;
    wait_dv(8000);
    wait_idle(100);
    repeat (300) @(negedge clk_in);
    #1;
    chk("busy_start_frames", cs_fall_cnt - frames0, 1);
    chk("busy_start_dv", dv_cycles - dvc0, 1);

    // Reset asserted at rising dclk edge 10
    do_start();
    hit = 0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clk_in); #1;
      if (rise_cnt >= 10) begin
        hit = 1;
        break;
      end
    end
    chk("rst_mid_reach", int'(hit), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", int'(mcp_cs_n), 1);
    chk("rst_mid_dclk", int'(mcp_dclk), 0);
    chk("rst_mid_busy", int'(bif.busy), 0);
    chk("rst_mid_dv", int'(bif.data_valid), 0);
    repeat (2) @(posedge clk_in);
    #1 rst_n = 1'b1;
    do_start();
    wait_dv(8000);
    chk("post_rst_data", int'(bif.data), 10'h2A5);
    chk("post_rst_din", int'(din_bits), 5'b11011);
    chk("post_rst_edges", rise_cnt, 17);
    wait_idle(100);

`ifdef MCP3008_AVG_EN
    frames0 = cs_fall_cnt;
    dvc0 = dv_cycles;
    avg_mode = 1'b1;
    do_start();
    wait_dv(8000);
    chk("avg_data", int'(bif.data), 10'h101);
    wait_idle(100);
    repeat (10) @(negedge clk_in);
    #1;
    chk("avg_frames", cs_fall_cnt - frames0, 4);
    chk("avg_gap_ok", int'(min_gap >= IDLE), 1);
    chk("avg_dv_once", dv_cycles - dvc0, 1);
    avg_mode = 1'b0;
`endif

    chk("dclk_low_when_cs_high", dclk_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
